// File: rtl/itcm_boot_sequencer_pkg.sv
// Shared state encodings and check-mode constants for the ITCM boot sequencer.
package itcm_boot_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_e;

  localparam int CHECK_AT_TIMEOUT = 0;
  localparam int CHECK_EARLY      = 1;

endpackage

// File: rtl/itcm_boot_sequencer_byte_word_packer.sv
// Byte-to-word packer: gathers bytes LSB-first, emits a full word, or a zero-padded partial on flush.
module itcm_boot_sequencer_byte_word_packer #(
  parameter int WW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          byte_en,
  input  logic [7:0]    byte_data,
  input  logic          flush,
  output logic          word_vld,
  output logic [WW-1:0] word
);
  localparam int NB = WW / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [WW-1:0] pack_q, merged;
  logic [CW-1:0] cnt_q;
  logic          full;

  always_comb begin
    merged = pack_q;
    for (int j = 0; j < NB; j++)
      if (byte_en && cnt_q == CW'(j)) merged[j*8 +: 8] = byte_data;
  end

  // Unused upper lanes of pack_q are always zero, so a flushed partial is already padded.
  assign full     = byte_en && (cnt_q == CW'(NB - 1));
  assign word_vld = full || (flush && cnt_q != '0);
  assign word     = merged;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pack_q <= '0;
      cnt_q  <= '0;
    end else if (word_vld) begin
      pack_q <= '0;
      cnt_q  <= '0;
    end else if (byte_en) begin
      pack_q <= merged;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/itcm_boot_sequencer.sv
// Boot sequencer: streams an image into banked ITCM with the core held in reset, then
// releases the core and judges a probed result register for pass/fail/timeout.
module itcm_boot_sequencer
  import itcm_boot_sequencer_pkg::*;
#(
  parameter int          ITCM_DEPTH     = 1024,
  parameter int          NUM_BANKS      = 2,
  parameter int          BANK_WIDTH     = 16,
  parameter int          TIMEOUT_CYCLES = 30,
  parameter logic [31:0] PASS_VALUE     = 32'd1,
  parameter int          CHECK_MODE     = 0,
  localparam int         WW             = NUM_BANKS * BANK_WIDTH,
  localparam int         AW             = $clog2(ITCM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  output logic [NUM_BANKS-1:0] mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [WW-1:0]        mem_wdata,
  output logic                 core_resetn,
  input  logic [31:0]          result_val,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 overflow,
  output logic [AW:0]          words_loaded
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e    state, state_nx;
  logic [TW-1:0] run_cnt;
  logic          fire, mem_full, byte_en, ovf_hit;
  logic          word_vld, match, at_limit, pass_set, fail_set;
  logic [WW-1:0] word, word_mapped;

  assign fire     = s_valid && s_ready;
  assign mem_full = (words_loaded == (AW+1)'(ITCM_DEPTH));
  assign byte_en  = (state == ST_LOAD) && fire && !mem_full;
  assign ovf_hit  = (state == ST_LOAD) && fire && mem_full;
  assign match    = (result_val == PASS_VALUE);
  assign at_limit = (run_cnt == TW'(TIMEOUT_CYCLES - 1));

  itcm_boot_sequencer_byte_word_packer #(.WW(WW)) u_packer (
    .clk      (clk),
    .resetn   (resetn),
    .byte_en  (byte_en),
    .byte_data(s_data),
    .flush    (state == ST_FLUSH),
    .word_vld (word_vld),
    .word     (word)
  );

  // Bank b carries halfword NUM_BANKS-1-b, so the lowest-addressed bytes land in the top bank.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign word_mapped[b*BANK_WIDTH +: BANK_WIDTH] = word[(NUM_BANKS-1-b)*BANK_WIDTH +: BANK_WIDTH];
  end

  always_comb begin
    pass_set = 1'b0;
    fail_set = 1'b0;
    if (state == ST_RUN) begin
      if (CHECK_MODE == CHECK_EARLY) begin
        pass_set = match;
        fail_set = !match && at_limit;
      end else begin
        pass_set = match && at_limit;
        fail_set = !match && at_limit;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:
        if (ovf_hit)                 state_nx = ST_DONE;
        else if (byte_en && s_last)  state_nx = word_vld ? ST_RELEASE : ST_FLUSH;
      ST_FLUSH:   state_nx = ST_RELEASE;
      ST_RELEASE: state_nx = ST_RUN;
      ST_RUN:     if (pass_set || fail_set) state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_DONE;
      default:    state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_LOAD;
      s_ready      <= 1'b0;
      mem_we       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      core_resetn  <= 1'b0;
      run_cnt      <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state   <= state_nx;
      s_ready <= (state_nx == ST_LOAD);
      mem_we  <= {NUM_BANKS{word_vld}};
      if (word_vld) begin
        mem_addr     <= words_loaded[AW-1:0];
        mem_wdata    <= word_mapped;
        words_loaded <= words_loaded + 1'b1;
      end
      if (state == ST_RELEASE) core_resetn <= 1'b1;
      if (state == ST_RELEASE)  run_cnt <= '0;
      else if (state == ST_RUN) run_cnt <= run_cnt + 1'b1;
      done     <= (state_nx == ST_DONE);
      pass     <= pass | pass_set;
      fail     <= fail | fail_set | ovf_hit;
      overflow <= overflow | ovf_hit;
    end
  end

endmodule

// File: tb/tb_itcm_boot_sequencer.sv
// Directed bench: d0 = defaults (mode 0), d1 = early-check mode, d2 = 4-word ITCM for overflow.
module tb_itcm_boot_sequencer;
  logic        clk = 1'b0;
  logic        resetn;
  logic        s_valid, s_last;
  logic [7:0]  s_data;
  logic [31:0] result_val;

  logic [2:0]  rdy, crn, dn, ps, fl, ov;
  logic [1:0]  we [3];
  logic [31:0] wd [3];
  logic [9:0]  addr0, addr1;
  logic [1:0]  addr2;
  logic [10:0] wl0, wl1;
  logic [2:0]  wl2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  img [0:31];
  logic [9:0]  waddr_q [$];
  logic [31:0] wdata_q [$];
  logic [1:0]  we_q [$];
  int          wcyc_q [$];
  int          nwr2 = 0;
  int          rise0 = 0;
  logic        crn0_d = 1'b0;

  itcm_boot_sequencer d0 (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(rdy[0]), .s_data(s_data),
    .s_last(s_last), .mem_we(we[0]), .mem_addr(addr0), .mem_wdata(wd[0]),
    .core_resetn(crn[0]), .result_val(result_val), .done(dn[0]), .pass(ps[0]),
    .fail(fl[0]), .overflow(ov[0]), .words_loaded(wl0));

  itcm_boot_sequencer #(.CHECK_MODE(1)) d1 (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(rdy[1]), .s_data(s_data),
    .s_last(s_last), .mem_we(we[1]), .mem_addr(addr1), .mem_wdata(wd[1]),
    .core_resetn(crn[1]), .result_val(result_val), .done(dn[1]), .pass(ps[1]),
    .fail(fl[1]), .overflow(ov[1]), .words_loaded(wl1));

  itcm_boot_sequencer #(.ITCM_DEPTH(4)) d2 (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(rdy[2]), .s_data(s_data),
    .s_last(s_last), .mem_we(we[2]), .mem_addr(addr2), .mem_wdata(wd[2]),
    .core_resetn(crn[2]), .result_val(result_val), .done(dn[2]), .pass(ps[2]),
    .fail(fl[2]), .overflow(ov[2]), .words_loaded(wl2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log keyed by the edge number that registered each write.
  always @(negedge clk) begin
    if (we[0] != 2'b00) begin
      waddr_q.push_back(addr0);
      wdata_q.push_back(wd[0]);
      we_q.push_back(we[0]);
      wcyc_q.push_back(cyc);
    end
    if (we[2] != 2'b00) nwr2 = nwr2 + 1;
    if (crn[0] && !crn0_d) rise0 = cyc;
    crn0_d = crn[0];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; result_val = 32'd0;
    @(negedge clk);
    waddr_q.delete(); wdata_q.delete(); we_q.delete(); wcyc_q.delete();
    nwr2 = 0; rise0 = 0;
    resetn = 1'b1;
    tick();
    chk("s_ready_after_reset", rdy[0], 1'b1);
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_data = img[i]; s_last = (i == n - 1);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_release();
    for (int i = 0; i < 20 && !crn[0]; i++) tick();
    chk("core_release", crn[0], 1'b1);
  endtask

  // Runs n core cycles starting from run cycle 0, result_val matching from cycle 'from'.
  task automatic run(input int from, input logic [31:0] vm, input logic [31:0] ve, input int n);
    for (int k = 0; k < n; k++) begin
      result_val = (k >= from) ? vm : ve;
      tick();
    end
  endtask

  task automatic load8();
    logic [63:0] v;
    v = 64'h0010_0193_0000_0013;
    for (int i = 0; i < 8; i++) img[i] = v[8*i +: 8];
  endtask

  initial begin
    int c;
    int n0;
    logic [39:0] v5;
    resetn = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; result_val = 32'd0;
    #3;
    chk("reset_flags", {rdy[0], crn[0], dn[0], ps[0], fl[0], ov[0]}, 6'b0);
    chk("reset_mem", {we[0], addr0, wd[0], wl0}, 55'b0);

    // 8-byte image, then mode-0 pass (result from cycle 3) and mode-1 early pass
    do_reset();
    load8();
    send(8);
    c = cyc;
    wait_release();
    run(3, 32'd1, 32'd0, 29);
    chk("m0_not_done_c29", {dn[0], ps[0]}, 2'b00);
    chk("m1_early_pass", {ps[1], dn[1], fl[1]}, 3'b110);
    result_val = 32'd1;
    tick();
    chk("m0_pass_c29", {ps[0], dn[0], fl[0]}, 3'b110);
    chk("t1_nwr", waddr_q.size(), 2);
    if (waddr_q.size() >= 2) begin
      chk("t1_addr0", waddr_q[0], 0);
      chk("t1_data0", wdata_q[0], 32'h0013_0000);
      chk("t1_we0", we_q[0], 2'b11);
      chk("t1_cyc0", wcyc_q[0], c - 4);
      chk("t1_addr1", waddr_q[1], 1);
      chk("t1_data1", wdata_q[1], 32'h0193_0010);
      chk("t1_cyc1", wcyc_q[1], c);
    end
    chk("t1_rise", rise0, c + 1);
    chk("t1_words", wl0, 2);
    n0 = waddr_q.size();
    send(4);
    tick();
    chk("done_ignores_bytes", waddr_q.size(), n0);
    chk("done_sticky", {rdy[0], crn[0], ps[0], dn[0]}, 4'b0111);

    // Never matches: both modes fail exactly at the end of cycle 29
    do_reset();
    send(8);
    wait_release();
    run(99, 32'd1, 32'd2, 29);
    chk("fail_not_early", {fl[0], fl[1], dn[0], dn[1]}, 4'b0);
    result_val = 32'd2;
    tick();
    chk("m0_fail_c29", {ps[0], fl[0], dn[0]}, 3'b011);
    chk("m1_fail_c29", {ps[1], fl[1], dn[1]}, 3'b011);

    // Mode 1 match arriving at run cycle 5, then async reset mid-run
    do_reset();
    send(8);
    wait_release();
    run(99, 32'd1, 32'd0, 5);
    chk("m1_before_c5", {ps[1], dn[1]}, 2'b00);
    result_val = 32'd1;
    tick();
    chk("m1_pass_c5", {ps[1], dn[1], fl[1]}, 3'b110);
    run(0, 32'd1, 32'd0, 3);
    #3 resetn = 1'b0;
    #1;
    chk("async_abort", {crn[0], crn[1], dn[1], ps[1], fl[0], rdy[0]}, 6'b0);
    chk("async_words", wl0, 0);
    do_reset();
    send(8);
    wait_release();
    run(0, 32'd1, 32'd0, 29);
    chk("reload_not_yet", ps[0], 1'b0);
    result_val = 32'd1;
    tick();
    chk("reload_pass", {ps[0], dn[0], fl[0]}, 3'b110);

    // 5-byte image: zero-padded flush word
    do_reset();
    v5 = 40'h55_4433_2211;
    for (int i = 0; i < 5; i++) img[i] = v5[8*i +: 8];
    send(5);
    c = cyc;
    wait_release();
    tick();
    chk("t2_nwr", waddr_q.size(), 2);
    if (waddr_q.size() >= 2) begin
      chk("t2_data0", wdata_q[0], 32'h2211_4433);
      chk("t2_addr1", waddr_q[1], 1);
      chk("t2_data1", wdata_q[1], 32'h0055_0000);
      chk("t2_cyc1", wcyc_q[1], c + 1);
    end
    chk("t2_rise", rise0, c + 2);
    chk("t2_words", wl0, 2);

    // Overflow on a 4-word ITCM with 17 bytes
    do_reset();
    for (int i = 0; i < 17; i++) img[i] = 8'(i + 1);
    send(17);
    chk("t5_ovf_now", {ov[2], fl[2], dn[2]}, 3'b111);
    run(0, 32'd1, 32'd1, 5);
    chk("t5_nwr", nwr2, 4);
    chk("t5_words", wl2, 4);
    chk("t5_flags", {ov[2], fl[2], ps[2], dn[2], crn[2], rdy[2]}, 6'b110100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
